data_table_rd_server: RTL
=========================

// Module: data_table_rd_server
// PURPOSE
//  Responder side of the data-table read protocol driven by the parallel search engines.
//  Owns the data RAM and generates the one-hot read time slot (rd_avail) for the engines.
//  Accepts one slot-qualified read per cycle and returns data after exactly RAM_LATENCY cycles,
//  with a per-engine data-valid strobe. Single write port from the table updater.
//  Flags protocol violations by engines that read outside their slot.
// PARAMETERS
//  ENGINES_CNT  3                 number of search engines / read slots (>=2)
//  RAM_LATENCY  2                 accept-to-data latency in cycles (>=1)
//  A_WIDTH      TABLE_ADDR_WIDTH  RAM address width; depth = 2**A_WIDTH
// PORTS
//  clk_i          in   1                       clock
//  rst_i          in   1                       reset, synchronous, active-high
//  rd_avail_o     out  ENGINES_CNT             one-hot read slot, bit g = engine g may read
//  rd_en_i        in   ENGINES_CNT             per-engine read request
//  rd_addr_i      in   ENGINES_CNT x A_WIDTH   per-engine read address
//  rd_data_o      out  ram_data_t              read data, shared by all engines
//  rd_data_val_o  out  ENGINES_CNT             one-cycle strobe to the owning engine
//  wr_en_i        in   1                       write strobe, always accepted
//  wr_addr_i      in   A_WIDTH                 write address
//  wr_data_i      in   ram_data_t              write data
//  slot_err_o     out  1                       sticky: read requested outside its slot
// BEHAVIOUR
//  - Reset values: rd_avail_o='d1, rd_data_o='0, rd_data_val_o='0, slot_err_o=0.
//    RAM contents are not cleared.
//  - rd_avail_o rotates left by one every cycle unconditionally (bit ENGINES_CNT-1 wraps to bit 0).
//  - Accept: rd_en_i[g] && rd_avail_o[g] at cycle T captures rd_addr_i[g] and the engine index g.
//    At most one accept per cycle.
//  - Response: at cycle T+RAM_LATENCY, rd_data_val_o = (1<<g) for exactly one cycle and
//    rd_data_o = RAM[addr].
//  - Back-to-back accepts in consecutive slots are fully pipelined; throughput is 1 read per cycle.
//  - Violation: rd_en_i[g] with rd_avail_o[g]=0 -> request ignored (no response) and
//    slot_err_o <= 1. Cleared only by rst_i.
//  - Write: wr_en_i updates RAM[wr_addr_i] at the clock edge; one write per cycle.
//    A write never stalls reads.
//  - Read/write ordering without bypass: data reflects writes issued strictly before cycle T.
//    A same-cycle write to the same address returns the old data.
//  - Reset mid-operation: all in-flight reads are discarded; no rd_data_val_o pulses follow.
//    rd_avail_o restarts from 'd1 on the cycle after rst_i deasserts.
//  - Engine index width = max(1, $clog2(ENGINES_CNT)). Addresses wrap naturally at 2**A_WIDTH.
// CONFIGURATION
//  DATA_TABLE_RAW_BYPASS_EN defined:
//    - Every in-flight read whose address equals wr_addr_i while wr_en_i is high has its data
//      replaced by wr_data_i.
//    - Returned data therefore reflects all writes issued in cycles <= T+RAM_LATENCY-1.
//    - Several writes to one address: the youngest write wins.
//  Undefined: no forwarding; ordering is as in BEHAVIOUR. Latency is identical in both builds.
// STRUCTURE
//  - Package hash_table: ram_data_t and TABLE_ADDR_WIDTH (existing).
//    Add DATA_TABLE_ENG_IDX_W helper function/constant.
//  - Sub-module data_table_rd_pipe: RAM_LATENCY-deep shift line of {valid, engine idx, addr, data}.
//    Performs the bypass compare/patch when the macro is enabled.
//  - Top level: slot ring, accept mux, RAM array, violation flag, one-hot val decode.
// TESTING
//  1. Reset, then idle 4 cycles -> rd_avail_o = 001,010,100,001; all outputs at reset values.
//  2. Write addr 5 = 0xAA; engine 1 reads addr 5 in its slot at T
//     -> T+2: rd_data_val_o=3'b010, rd_data_o=0xAA.
//  3. Engine 0 asserts rd_en_i while rd_avail_o=3'b100 -> no val pulse ever;
//     slot_err_o=1 and stays 1 until rst_i.
//  4. RAM[7]=0x11; engine 0 reads 7 at T; write 7=0x55 at T+1
//     -> T+2 data 0x55 with bypass, 0x11 without.
//  5. All 3 engines read in every slot for 9 cycles (addr = cycle#)
//     -> 9 consecutive val pulses, correct engine, correct data, order preserved.
//  6. Accept at T, rst_i high at T+1 -> no val pulse at T+2; rd_avail_o=001 after reset release.

Source files
------------

// File: rtl/hash_table_pkg.sv
// Shared hash-table types: RAM data word, table address width and
// the engine-index width helper used by the data-table read server.
package hash_table;

  localparam int TABLE_ADDR_WIDTH = 8;

  typedef logic [15:0] ram_data_t;

  function automatic int data_table_eng_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/data_table_rd_pipe.sv
// Fixed-latency shift line carrying accepted reads to the response port.
// DATA_TABLE_RAW_BYPASS_EN patches in-flight data with same-address writes.
module data_table_rd_pipe
  import hash_table::*;
#(
  parameter int LAT = 2,
  parameter int IW  = 2,
  parameter int AW  = TABLE_ADDR_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [IW-1:0]   in_idx,
  input  logic [AW-1:0]   in_addr,
  input  ram_data_t       in_data,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  ram_data_t       wr_data,
  output logic            out_valid,
  output logic [IW-1:0]   out_idx,
  output ram_data_t       out_data
);

  for (genvar i = 0; i < LAT; i++) begin : g_stg
    logic          p_vld;
    logic [IW-1:0] p_idx;
    logic [AW-1:0] p_adr;
    ram_data_t     p_dat;
    ram_data_t     n_dat;

    logic          r_vld;
    logic [IW-1:0] r_idx;
    logic [AW-1:0] r_adr;
    ram_data_t     r_dat;

    if (i == 0) begin : g_head
      assign p_vld = in_valid;
      assign p_idx = in_idx;
      assign p_adr = in_addr;
      assign p_dat = in_data;
    end else begin : g_body
      assign p_vld = g_stg[i-1].r_vld;
      assign p_idx = g_stg[i-1].r_idx;
      assign p_adr = g_stg[i-1].r_adr;
      assign p_dat = g_stg[i-1].r_dat;
    end

`ifdef DATA_TABLE_RAW_BYPASS_EN
    // later stages see later writes, so the youngest write wins
    assign n_dat = (wr_en && wr_addr == p_adr) ? wr_data : p_dat;
`else
    assign n_dat = p_dat;
`endif

    // payload holds when idle so the output keeps the last read value
    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld <= 1'b0;
        r_idx <= '0;
        r_adr <= '0;
        r_dat <= '0;
      end else begin
        r_vld <= p_vld;
        if (p_vld) begin
          r_idx <= p_idx;
          r_adr <= p_adr;
          r_dat <= n_dat;
        end
      end
    end
  end

  assign out_valid = g_stg[LAT-1].r_vld;
  assign out_idx   = g_stg[LAT-1].r_idx;
  assign out_data  = g_stg[LAT-1].r_dat;

`ifdef DATA_TABLE_RAW_BYPASS_EN
  logic unused;
  assign unused = ^g_stg[LAT-1].r_adr;
`else
  logic unused;
  assign unused = ^{wr_en, wr_addr, wr_data, g_stg[LAT-1].r_adr};
`endif

endmodule

// File: rtl/data_table_rd_server.sv
// Data-table read responder: slot ring, RAM, fixed-latency read return.
// Build option DATA_TABLE_RAW_BYPASS_EN enables write-to-read forwarding.
module data_table_rd_server
  import hash_table::*;
#(
  parameter int ENGINES_CNT = 3,
  parameter int RAM_LATENCY = 2,
  parameter int A_WIDTH     = TABLE_ADDR_WIDTH
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  output logic [ENGINES_CNT-1:0]              rd_avail_o,
  input  logic [ENGINES_CNT-1:0]              rd_en_i,
  input  logic [ENGINES_CNT-1:0][A_WIDTH-1:0] rd_addr_i,
  output ram_data_t                           rd_data_o,
  output logic [ENGINES_CNT-1:0]              rd_data_val_o,
  input  logic                                wr_en_i,
  input  logic [A_WIDTH-1:0]                  wr_addr_i,
  input  ram_data_t                           wr_data_i,
  output logic                                slot_err_o
);

  localparam int IW = data_table_eng_idx_w(ENGINES_CNT);

  ram_data_t ram [2**A_WIDTH];

  logic [ENGINES_CNT-1:0] avail;
  logic [ENGINES_CNT-1:0] hit;
  logic                   acc_vld;
  logic [IW-1:0]          acc_idx;
  logic [A_WIDTH-1:0]     acc_addr;
  logic                   out_vld;
  logic [IW-1:0]          out_idx;
  ram_data_t              out_data;
  logic                   err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      avail <= ENGINES_CNT'(1);
    end else begin
      avail <= {avail[ENGINES_CNT-2:0], avail[ENGINES_CNT-1]};
    end
  end

  // slot is one-hot, so at most one request can hit
  assign hit     = rd_en_i & avail;
  assign acc_vld = |hit;

  always_comb begin
    acc_idx  = '0;
    acc_addr = '0;
    for (int g = 0; g < ENGINES_CNT; g++) begin
      if (hit[g]) begin
        acc_idx  = IW'(g);
        acc_addr = rd_addr_i[g];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      ram[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err <= 1'b0;
    end else if (|(rd_en_i & ~avail)) begin
      err <= 1'b1;
    end
  end

  data_table_rd_pipe #(
    .LAT (RAM_LATENCY),
    .IW  (IW),
    .AW  (A_WIDTH)
  ) u_pipe (
    .clk       (clk_i),
    .rst       (rst_i),
    .in_valid  (acc_vld),
    .in_idx    (acc_idx),
    .in_addr   (acc_addr),
    .in_data   (ram[acc_addr]),
    .wr_en     (wr_en_i),
    .wr_addr   (wr_addr_i),
    .wr_data   (wr_data_i),
    .out_valid (out_vld),
    .out_idx   (out_idx),
    .out_data  (out_data)
  );

  assign rd_avail_o    = avail;
  assign rd_data_o     = out_data;
  assign rd_data_val_o = out_vld ? (ENGINES_CNT'(1) << out_idx) : '0;
  assign slot_err_o    = err;

endmodule
